music_sched: RTL and testbench
==============================

MUSIC_SCHED -- requirements
Module: music_sched

Interface
REQ-001 SHALL have parameter SETTLE, default 2: number of cycles after a start pulse before music_idle is sampled.
REQ-002 SHALL have parameter PREEMPT_MASK, default 4'b0001: requesters allowed to preempt a lower-priority song.
REQ-003 SHALL have port Clock, input, 1: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: when low, no song plays and all pending requests are discarded.
REQ-006 SHALL have port req, input, 4: one-cycle request pulses; index 0 is highest priority; requester i always selects song i.
REQ-007 SHALL have port music_idle, input, 1: high when the player's address equals its stop bound.
REQ-008 SHALL have port start, output, 1: one-cycle load strobe to the player.
REQ-009 SHALL have port start_addr, output, 12: song start address; valid while start is high.
REQ-010 SHALL have port stop_addr, output, 12: song stop address; valid while start is high.
REQ-011 SHALL have port interrupt, output, 1: one-cycle abort strobe to the player.
REQ-012 SHALL have port ack, output, 4: one-cycle pulse on bit i when song i is started.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port cur_song, output, 2: index of the song started last; holds its value in IDLE.

Function
REQ-015 SHALL keep one sticky pending bit per requester: set by req[i], cleared in the cycle song i is started; a repeated req[i] while pending SHALL coalesce.
REQ-016 SHALL select the lowest-index pending bit (fixed priority).
REQ-017 SHALL implement FSM states IDLE, LOAD, SETTLE, PLAY, ABORT.
REQ-018 From IDLE, with any pending bit set and enable high, the FSM SHALL go to LOAD.
REQ-019 In LOAD, the block SHALL drive start=1, start_addr/stop_addr from the song table, pulse ack[sel], update cur_song and clear pending[sel], then go to SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter, then go to PLAY; music_idle SHALL be ignored during SETTLE.
REQ-021 In PLAY, music_idle=1 SHALL return the FSM to IDLE. The next LOAD SHALL follow no earlier than one cycle after IDLE.
REQ-022 In PLAY or SETTLE, a pending requester j with PREEMPT_MASK[j]=1 and j<cur_song SHALL move the FSM to ABORT.
REQ-023 ABORT SHALL drive interrupt=1 for one cycle, then go to LOAD. start and interrupt SHALL never be high in the same cycle.
REQ-024 A req arriving in the same cycle its pending bit is cleared SHALL re-set that bit, so the song replays.
REQ-025 A request for the song currently playing SHALL queue it for replay after the current song finishes; it SHALL NOT cause preemption.
REQ-026 enable falling in SETTLE or PLAY SHALL clear all pending bits and go to ABORT, then to IDLE (not LOAD). While enable is low, req SHALL be ignored.
REQ-027 start_addr and stop_addr SHALL be 0 whenever start is 0.

Reset
REQ-028 Reset low SHALL asynchronously force state IDLE, pending 0, start 0, interrupt 0, ack 0, busy 0, cur_song 0, start_addr 0, stop_addr 0 and the settle counter 0.
REQ-029 Release from reset SHALL take effect at the first rising Clock edge with Reset high; no request pulse is retained across reset.

Structure
REQ-030 Package music_pkg SHALL hold the 4-entry song table (12-bit start and stop per song) and the FSM state enum.
REQ-031 The fixed-priority selector SHALL be sub-module music_arb (4-bit pending in; one-hot grant and 2-bit index out); all other logic stays in music_sched.

Verification
REQ-032 Scenario 1: req=4'b0100 in IDLE -> next cycle LOAD with start=1, table[2] addresses, ack=4'b0100; busy until 1 cycle after music_idle rises.
REQ-033 Scenario 2: req=4'b1010 in one cycle -> song 1 starts first, song 3 starts after song 1 finishes; each ack pulses exactly once.
REQ-034 Scenario 3: song 2 in PLAY, req[0] pulses -> interrupt=1 for one cycle, then start with table[0]; song 2 is not replayed.
REQ-035 Scenario 4: song 1 in PLAY, req[2] pulses -> no interrupt; song 2 starts after song 1 finishes.
REQ-036 Scenario 5: enable dropped in PLAY with 4'b0110 pending -> one interrupt pulse, return to IDLE, pending=0, no start.
REQ-037 Scenario 6: Reset asserted during SETTLE -> all outputs 0 immediately; no start after release until a new req.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types for the music scheduler: the FSM state encoding and the
// fixed 4-entry song table that maps each requester to a start/stop range.
package music_pkg;

    localparam int NUM_SONGS = 4;
    localparam int SONG_W    = 2;
    localparam int ADDR_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_PLAY,
        ST_ABORT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] startAddr;
        logic [ADDR_W-1:0] stopAddr;
    } songEntry_t;

    function automatic songEntry_t songLookup(input logic [SONG_W-1:0] idx);
        songEntry_t e;
        case (idx)
            2'd0:    begin e.startAddr = 12'h000; e.stopAddr = 12'h0FF; end
            2'd1:    begin e.startAddr = 12'h100; e.stopAddr = 12'h2FF; end
            2'd2:    begin e.startAddr = 12'h300; e.stopAddr = 12'h47F; end
            default: begin e.startAddr = 12'h480; e.stopAddr = 12'h7FF; end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/music_arb.sv
// Fixed-priority selector: the lowest-index pending requester wins.
import music_pkg::*;

module music_arb (
    input  logic [NUM_SONGS-1:0] pend_i,
    output logic [NUM_SONGS-1:0] grant_o,
    output logic [SONG_W-1:0]    idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int i = NUM_SONGS - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = SONG_W'(i);
            end
        end
    end

endmodule

// File: rtl/music_sched.sv
// Music scheduler: latches song requests, loads the highest-priority one into
// the player, and aborts the current song for preempting or disable events.
import music_pkg::*;

module music_sched #(
    parameter int             SETTLE       = 2,
    parameter logic [3:0]     PREEMPT_MASK = 4'b0001
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              enable,
    input  logic [3:0]        req,
    input  logic              music_idle,
    output logic              start,
    output logic [11:0]       start_addr,
    output logic [11:0]       stop_addr,
    output logic              interrupt,
    output logic [3:0]        ack,
    output logic              busy,
    output logic [1:0]        cur_song
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    state_t                 state_q, state_d;
    logic [NUM_SONGS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]       settleCnt_q, settleCnt_d;
    logic [SONG_W-1:0]      curSong_q, curSong_d;
    logic [NUM_SONGS-1:0]   grant;
    logic [SONG_W-1:0]      selIdx;
    logic                   preempt;
    songEntry_t             entry;

    music_arb u_arb (
        .pend_i  (pending_q),
        .grant_o (grant),
        .idx_o   (selIdx)
    );

    // Only strictly higher-priority, preempt-capable requesters may abort a song.
    always_comb begin
        preempt = 1'b0;
        for (int j = 0; j < NUM_SONGS; j++) begin
            if (pending_q[j] && PREEMPT_MASK[j] && (SONG_W'(j) < curSong_q)) begin
                preempt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        settleCnt_d = settleCnt_q;
        curSong_d   = curSong_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && ((pending_q | req) != '0)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pending_d   = pending_q & ~grant;
                curSong_d   = selIdx;
                settleCnt_d = CNT_W'(SETTLE);
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                settleCnt_d = settleCnt_q - CNT_W'(1);
                if (!enable || preempt)              state_d = ST_ABORT;
                else if (settleCnt_q <= CNT_W'(1))   state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!enable || preempt)  state_d = ST_ABORT;
                else if (music_idle)     state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = (enable && (pending_q != '0)) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // New requests are merged after the LOAD clear so a same-cycle req replays.
        if (enable) pending_d = pending_d | req;
        else        pending_d = '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            settleCnt_q <= '0;
            curSong_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            settleCnt_q <= settleCnt_d;
            curSong_q   <= curSong_d;
        end
    end

    always_comb begin
        entry      = songLookup(selIdx);
        start      = (state_q == ST_LOAD);
        interrupt  = (state_q == ST_ABORT);
        busy       = (state_q != ST_IDLE);
        start_addr = start ? entry.startAddr : '0;
        stop_addr  = start ? entry.stopAddr  : '0;
        ack        = start ? grant : '0;
        cur_song   = curSong_q;
    end

endmodule

// File: tb/tb_music_sched.sv
// Scoreboard bench for music_sched: directed requests push expected start and
// interrupt events; a monitor pops and compares them as the DUT emits them.
module tb_music_sched;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        enable;
    logic [3:0]  req;
    logic        music_idle;
    logic        start;
    logic [11:0] start_addr;
    logic [11:0] stop_addr;
    logic        interrupt;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  cur_song;

    typedef struct {
        logic       isStart;
        logic [1:0] song;
    } evt_t;

    evt_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          playLen = 4;
    int          playCnt = 0;
    logic [11:0] refStart [4];
    logic [11:0] refStop  [4];

    music_sched #(.SETTLE(2), .PREEMPT_MASK(4'b0001)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .enable     (enable),
        .req        (req),
        .music_idle (music_idle),
        .start      (start),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .interrupt  (interrupt),
        .ack        (ack),
        .busy       (busy),
        .cur_song   (cur_song)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge Clock);
        req = r;
        @(negedge Clock);
        req = '0;
    endtask

    task automatic expectStart(input int s);
        evt_t e;
        e.isStart = 1'b1;
        e.song    = 2'(s);
        expQ.push_back(e);
    endtask

    task automatic expectIntr();
        evt_t e;
        e.isStart = 1'b0;
        e.song    = 2'd0;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " start"},      32'(start), 0);
        checkOutput({tag, " interrupt"},  32'(interrupt), 0);
        checkOutput({tag, " ack"},        32'(ack), 0);
        checkOutput({tag, " busy"},       32'(busy), 0);
        checkOutput({tag, " cur_song"},   32'(cur_song), 0);
        checkOutput({tag, " start_addr"}, 32'(start_addr), 0);
        checkOutput({tag, " stop_addr"},  32'(stop_addr), 0);
    endtask

    task automatic waitIdleLevel(input logic lvl, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            if (music_idle == lvl) break;
            @(negedge Clock);
        end
        checkOutput(name, 32'(music_idle), 32'(lvl));
    endtask

    task automatic waitQuiet(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge Clock);
            if (!busy && expQ.size() == 0) break;
        end
        checkOutput({name, " pending events"}, 32'(expQ.size()), 0);
        repeat (3) @(negedge Clock);
        checkOutput({name, " busy settled"}, 32'(busy), 0);
    endtask

    // Player model: stops at its bound playLen cycles after a load, or on abort.
    initial begin
        music_idle = 1'b1;
        forever begin
            @(posedge Clock);
            #2;
            if (!Reset) begin
                music_idle = 1'b1;
                playCnt    = 0;
            end else if (start) begin
                music_idle = 1'b0;
                playCnt    = playLen;
            end else if (interrupt) begin
                music_idle = 1'b1;
                playCnt    = 0;
            end else if (playCnt > 0) begin
                playCnt--;
                if (playCnt == 0) music_idle = 1'b1;
            end
        end
    end

    initial begin
        evt_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                if (start || interrupt) begin
                    checkOutput("start/interrupt exclusive", 32'(start & interrupt), 0);
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected event: start=%0b interrupt=%0b, required none", start, interrupt);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("event kind (1=start)", 32'(start), 32'(e.isStart));
                        if (e.isStart && start) begin
                            oh = '0;
                            oh[e.song] = 1'b1;
                            checkOutput("start_addr", 32'(start_addr), 32'(refStart[e.song]));
                            checkOutput("stop_addr",  32'(stop_addr),  32'(refStop[e.song]));
                            checkOutput("ack",        32'(ack),        32'(oh));
                        end
                    end
                end else begin
                    checkOutput("quiet start_addr", 32'(start_addr), 0);
                    checkOutput("quiet stop_addr",  32'(stop_addr), 0);
                    checkOutput("quiet ack",        32'(ack), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        refStart[0] = 12'h000; refStop[0] = 12'h0FF;
        refStart[1] = 12'h100; refStop[1] = 12'h2FF;
        refStart[2] = 12'h300; refStop[2] = 12'h47F;
        refStart[3] = 12'h480; refStop[3] = 12'h7FF;
        Reset  = 1'b0;
        enable = 1'b1;
        req    = '0;
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Single request; busy drops one cycle after the player goes idle.
        expectStart(2);
        applyStimulus(4'b0100);
        waitIdleLevel(1'b0, 20, "S1 player running");
        waitIdleLevel(1'b1, 50, "S1 player finished");
        checkOutput("S1 busy at idle rise", 32'(busy), 1);
        @(negedge Clock);
        checkOutput("S1 busy after idle", 32'(busy), 0);
        checkOutput("S1 cur_song", 32'(cur_song), 2);

        // Request repeated during LOAD re-arms the song for a replay.
        expectStart(2);
        expectStart(2);
        @(negedge Clock);
        req = 4'b0100;
        @(negedge Clock);
        req = 4'b0100;
        @(negedge Clock);
        req = '0;
        waitQuiet(200, "S1b");

        expectStart(1);
        expectStart(3);
        applyStimulus(4'b1010);
        waitQuiet(200, "S2");
        checkOutput("S2 cur_song", 32'(cur_song), 3);

        playLen = 10;
        expectStart(2);
        applyStimulus(4'b0100);
        repeat (3) @(negedge Clock);
        expectIntr();
        expectStart(0);
        applyStimulus(4'b0001);
        waitQuiet(200, "S3");
        checkOutput("S3 cur_song", 32'(cur_song), 0);

        expectStart(1);
        expectStart(2);
        applyStimulus(4'b0010);
        repeat (3) @(negedge Clock);
        applyStimulus(4'b0100);
        waitQuiet(200, "S4");
        checkOutput("S4 cur_song", 32'(cur_song), 2);

        expectStart(3);
        expectStart(3);
        applyStimulus(4'b1000);
        repeat (3) @(negedge Clock);
        applyStimulus(4'b1000);
        waitQuiet(200, "S4b");
        checkOutput("S4b cur_song", 32'(cur_song), 3);

        // Disable while playing with lower-priority songs pending.
        expectStart(3);
        applyStimulus(4'b1000);
        repeat (3) @(negedge Clock);
        applyStimulus(4'b0110);
        expectIntr();
        enable = 1'b0;
        repeat (2) @(negedge Clock);
        checkOutput("S5 busy after abort", 32'(busy), 0);
        applyStimulus(4'b0001);
        repeat (2) @(negedge Clock);
        enable = 1'b1;
        repeat (6) @(negedge Clock);
        checkOutput("S5 busy after re-enable", 32'(busy), 0);
        checkOutput("S5 pending events", 32'(expQ.size()), 0);

        // Reset in SETTLE clears everything at once.
        expectStart(1);
        applyStimulus(4'b0010);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkAllZero("S6 reset");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        checkOutput("S6 busy after release", 32'(busy), 0);
        expectStart(3);
        applyStimulus(4'b1000);
        waitQuiet(200, "S6");
        checkOutput("S6 cur_song", 32'(cur_song), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
